mux_sel_arbiter: RTL and testbench

Round-robin burst arbiter that drives the select line of the team's 2:1 multiplexer. It arbitrates two requesters (a, b), then locks the grant for a whole burst until the last beat or a beat-count limit, so `sel` never changes mid-burst. `sel` uses the mux convention: sel=1 passes `a`, sel=0 passes `b`. It sits directly upstream of the mux; `sel` connects straight to the mux select input.

---
 rtl/mux_sel_arbiter.sv | 119 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_sel_arbiter
// Description : Two-requester round-robin burst arbiter driving the select of
//               a 2:1 mux (sel=1 passes a, sel=0 passes b).
// Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_arbiter #(
    parameter int MAX_BEATS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic last_a,
    input  logic req_b,
    input  logic last_b,
    input  logic out_ready,
    output logic sel,
    output logic gnt_a,
    output logic gnt_b,
    output logic busy,
    output logic force_rel
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GNT_A = 2'd1;
    localparam logic [1:0] c_GNT_B = 2'd2;

    localparam logic [CNT_W:0] c_LIMIT = (CNT_W + 1)'(MAX_BEATS);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_cnt_inc;
    logic             r_last_winner;   // 1 = a won last, 0 = b won last
    logic             r_sel;
    logic             r_gnt_a;
    logic             r_gnt_b;
    logic             r_force_rel;

    logic w_xfer_a;
    logic w_xfer_b;
    logic w_xfer;
    logic w_last;
    logic w_limit;
    logic w_release;
    logic w_force;

    assign w_xfer_a  = (r_state == c_GNT_A) & req_a & out_ready;
    assign w_xfer_b  = (r_state == c_GNT_B) & req_b & out_ready;
    assign w_xfer    = w_xfer_a | w_xfer_b;
    assign w_last    = (w_xfer_a & last_a) | (w_xfer_b & last_b);
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_limit   = (w_cnt_inc == c_LIMIT);
    assign w_release = w_xfer & (w_last | w_limit);
    // A beat that is both last and at the limit counts as a normal release.
    assign w_force   = w_xfer & w_limit & ~w_last;

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (req_a && req_b)
                    w_next = r_last_winner ? c_GNT_B : c_GNT_A;
                else if (req_a)
                    w_next = c_GNT_A;
                else if (req_b)
                    w_next = c_GNT_B;
            end
            c_GNT_A: begin
                if (w_release)
                    w_next = req_b ? c_GNT_B : (req_a ? c_GNT_A : c_IDLE);
            end
            c_GNT_B: begin
                if (w_release)
                    w_next = req_a ? c_GNT_A : (req_b ? c_GNT_B : c_IDLE);
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_cnt         <= '0;
            r_last_winner <= 1'b0;
            r_sel         <= 1'b0;
            r_gnt_a       <= 1'b0;
            r_gnt_b       <= 1'b0;
            r_force_rel   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_gnt_a     <= (w_next == c_GNT_A);
            r_gnt_b     <= (w_next == c_GNT_B);
            r_force_rel <= w_force;
            if (w_release) begin
                r_cnt         <= '0;
                r_last_winner <= w_xfer_a;
            end else if (w_xfer) begin
                r_cnt <= w_cnt_inc[CNT_W-1:0];
            end
            // sel only moves when a grant is (re)entered; IDLE keeps it.
            if (w_next == c_GNT_A)
                r_sel <= 1'b1;
            else if (w_next == c_GNT_B)
                r_sel <= 1'b0;
        end
    end

    assign sel       = r_sel;
    assign gnt_a     = r_gnt_a;
    assign gnt_b     = r_gnt_b;
    assign busy      = r_gnt_a | r_gnt_b;
    assign force_rel = r_force_rel;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_sel_arbiter
// Description : Vector-table bench for mux_sel_arbiter with MAX_BEATS=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_sel_arbiter;

    logic clk = 1'b0;
    logic rst, req_a, last_a, req_b, last_b, out_ready;
    logic sel, gnt_a, gnt_b, busy, force_rel;

    always #5 clk = ~clk;

    mux_sel_arbiter #(.MAX_BEATS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .last_a    (last_a),
        .req_b     (req_b),
        .last_b    (last_b),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .busy      (busy),
        .force_rel (force_rel)
    );

    // Inputs sampled at an edge and outputs expected just after that edge.
    typedef struct packed {
        logic       rst;
        logic       ra;
        logic       la;
        logic       rb;
        logic       lb;
        logic       rdy;
        logic [4:0] exp;   // {sel, gnt_a, gnt_b, busy, force_rel}
    } vec_t;

    vec_t       vecs[$];
    logic [4:0] sb[$];
    int         errors = 0;
    int         checks = 0;

    task automatic add(input logic r, input logic ra, input logic la,
                       input logic rb, input logic lb, input logic rdy,
                       input logic [4:0] e);
        vec_t v;
        v.rst = r; v.ra = ra; v.la = la; v.rb = rb; v.lb = lb; v.rdy = rdy;
        v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [4:0] got, want;
        rst = 1'b1; req_a = 1'b0; last_a = 1'b0;
        req_b = 1'b0; last_b = 1'b0; out_ready = 1'b0;

        // Reset held with both requesting, then a wins first contention.
        add(1,1,0,1,0,0, 5'b00000);
        add(1,1,0,1,0,0, 5'b00000);
        add(0,1,0,1,0,1, 5'b11010);
        // Contention: a's 2nd beat is last, b follows with no bubble.
        add(0,1,0,1,0,1, 5'b11010);
        add(0,1,1,1,0,1, 5'b00110);
        // b releases on last, a requesting -> a granted.
        add(0,1,0,1,1,1, 5'b11010);
        // Limit release: 4 beats without last, force pulse, regrant a.
        add(0,1,0,0,0,1, 5'b11010);
        add(0,1,0,0,0,1, 5'b11010);
        add(0,1,0,0,0,1, 5'b11010);
        add(0,1,0,0,0,1, 5'b11011);
        // Counter restarted: another full 4 beats before the next pulse.
        add(0,1,0,0,0,1, 5'b11010);
        add(0,1,0,0,0,1, 5'b11010);
        add(0,1,0,0,0,1, 5'b11010);
        add(0,1,0,0,0,1, 5'b11011);
        // Hand over to b, then stall 5 cycles (last_b without ready ignored).
        add(0,1,1,1,0,1, 5'b00110);
        add(0,0,0,1,0,0, 5'b00110);
        add(0,0,0,1,0,0, 5'b00110);
        add(0,0,0,1,1,0, 5'b00110);
        add(0,0,0,1,0,0, 5'b00110);
        add(0,0,0,1,0,0, 5'b00110);
        add(0,1,0,1,1,1, 5'b11010);
        // Request drop: a holds its grant while b waits.
        add(0,0,0,1,0,1, 5'b11010);
        add(0,0,0,1,0,1, 5'b11010);
        add(0,0,0,1,0,1, 5'b11010);
        add(0,1,1,1,0,1, 5'b00110);
        // Reset after 2 b beats, then a wins contention.
        add(0,0,0,1,0,1, 5'b00110);
        add(0,0,0,1,0,1, 5'b00110);
        add(1,1,0,1,0,1, 5'b00000);
        add(0,1,0,1,0,0, 5'b11010);
        // Counter cleared by reset: full 4 beats to force release.
        add(0,1,0,0,0,1, 5'b11010);
        add(0,1,0,0,0,1, 5'b11010);
        add(0,1,0,0,0,1, 5'b11010);
        add(0,1,0,0,0,1, 5'b11011);
        // Idle with nothing requested, then b alone.
        add(1,0,0,0,0,0, 5'b00000);
        add(0,0,0,0,0,0, 5'b00000);
        add(0,0,0,1,0,0, 5'b00110);
        add(0,0,0,1,1,1, 5'b00110);
        // Last coincides with limit: no force pulse.
        add(0,0,0,1,0,1, 5'b00110);
        add(0,0,0,1,0,1, 5'b00110);
        add(0,0,0,1,0,1, 5'b00110);
        add(0,0,0,1,1,1, 5'b00110);
        add(0,1,0,1,0,1, 5'b00110);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; req_a = vecs[i].ra; last_a = vecs[i].la;
            req_b = vecs[i].rb; last_b = vecs[i].lb; out_ready = vecs[i].rdy;
            sb.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            got  = {sel, gnt_a, gnt_b, busy, force_rel};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL row%0d outputs{sel,gnt_a,gnt_b,busy,force_rel}: got %b expected %b",
                         i, got, want);
            end
            checks++;
            if ((gnt_a & gnt_b) !== 1'b0 || busy !== (gnt_a | gnt_b)) begin
                errors++;
                $display("FAIL row%0d invariant: gnt_a=%b gnt_b=%b busy=%b expected exclusive grants and busy=gnt_a|gnt_b",
                         i, gnt_a, gnt_b, busy);
            end
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
